// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the softmax / layer / decoder blocks.
package nn_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned CLASS_ID_W  = $clog2(NUM_CLASSES);
  localparam logic [DATA_W-1:0] Q15_ONE = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/topk2_update.sv
// Folds one lane into the running best / runner-up slots; strict compares keep the lower index on ties.
module topk2_update #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 4
) (
  input  logic [DATA_W-1:0] v,
  input  logic [ID_W-1:0]   idx,
  input  logic              best_empty,
  input  logic [DATA_W-1:0] best_val,
  input  logic [ID_W-1:0]   best_id,
  input  logic              second_empty,
  input  logic [DATA_W-1:0] second_val,
  input  logic [ID_W-1:0]   second_id,
  output logic              best_empty_next,
  output logic [DATA_W-1:0] best_val_next,
  output logic [ID_W-1:0]   best_id_next,
  output logic              second_empty_next,
  output logic [DATA_W-1:0] second_val_next,
  output logic [ID_W-1:0]   second_id_next
);

  always_comb begin
    best_empty_next   = best_empty;
    best_val_next     = best_val;
    best_id_next      = best_id;
    second_empty_next = second_empty;
    second_val_next   = second_val;
    second_id_next    = second_id;
    if (best_empty || (v > best_val)) begin
      // Old best (possibly empty) drops to runner-up.
      second_empty_next = best_empty;
      second_val_next   = best_val;
      second_id_next    = best_id;
      best_empty_next   = 1'b0;
      best_val_next     = v;
      best_id_next      = idx;
    end else if (second_empty || (v > second_val)) begin
      second_empty_next = 1'b0;
      second_val_next   = v;
      second_id_next    = idx;
    end
  end

endmodule

// File: rtl/softmax_argmax_decoder.sv
// Snapshots a softmax probability vector, scans one lane per cycle and reports top-1/top-2 results.
module softmax_argmax_decoder
  import nn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int unsigned DATA_W      = nn_pkg::DATA_W,
  parameter logic [DATA_W-1:0] CONF_THRESH = 16'h4000,
  localparam int unsigned ID_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int unsigned IDX_W = $clog2(NUM_CLASSES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLASSES*DATA_W-1:0] softmax_in,
  input  logic                          in_valid,
  output logic                          busy,
  output logic [ID_W-1:0]               class_id,
  output logic [DATA_W-1:0]             class_prob,
  output logic [ID_W-1:0]               second_id,
  output logic [DATA_W-1:0]             margin,
  output logic                          confident,
  output logic                          out_valid,
  output logic                          overrun
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] snap [NUM_CLASSES];
  logic [DATA_W-1:0] lane_val;

  logic              best_empty, second_empty;
  logic [DATA_W-1:0] best_val, second_val;
  logic [ID_W-1:0]   best_id, second_id_r;

  logic              best_empty_nxt, second_empty_nxt;
  logic [DATA_W-1:0] best_val_nxt, second_val_nxt;
  logic [ID_W-1:0]   best_id_nxt, second_id_nxt;

  // Lane mux; idx == NUM_CLASSES (finish step) selects nothing.
  always_comb begin
    lane_val = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (idx == IDX_W'(i)) lane_val = snap[i];
    end
  end

  topk2_update #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_topk2 (
    .v                 (lane_val),
    .idx               (ID_W'(idx)),
    .best_empty        (best_empty),
    .best_val          (best_val),
    .best_id           (best_id),
    .second_empty      (second_empty),
    .second_val        (second_val),
    .second_id         (second_id_r),
    .best_empty_next   (best_empty_nxt),
    .best_val_next     (best_val_nxt),
    .best_id_next      (best_id_nxt),
    .second_empty_next (second_empty_nxt),
    .second_val_next   (second_val_nxt),
    .second_id_next    (second_id_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      best_empty   <= 1'b1;
      best_val     <= '0;
      best_id      <= '0;
      second_empty <= 1'b1;
      second_val   <= '0;
      second_id_r  <= '0;
      class_id     <= '0;
      class_prob   <= '0;
      second_id    <= '0;
      margin       <= '0;
      confident    <= 1'b0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
              snap[i] <= softmax_in[i*DATA_W +: DATA_W];
            end
            best_empty   <= 1'b1;
            second_empty <= 1'b1;
            idx          <= '0;
            busy         <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          overrun <= in_valid;
          if (idx == IDX_W'(NUM_CLASSES)) begin
            // All lanes folded: publish; an empty runner-up reads as value 0, id 0.
            class_id   <= best_id;
            class_prob <= best_val;
            second_id  <= second_empty ? '0 : second_id_r;
            margin     <= best_val - (second_empty ? '0 : second_val);
            confident  <= (best_val >= CONF_THRESH);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            best_empty   <= best_empty_nxt;
            best_val     <= best_val_nxt;
            best_id      <= best_id_nxt;
            second_empty <= second_empty_nxt;
            second_val   <= second_val_nxt;
            second_id_r  <= second_id_nxt;
            idx          <= idx + 1'b1;
          end
        end
        DONE: begin
          overrun <= in_valid;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_argmax_decoder.sv
// Randomized and directed checks of the argmax decoder against a whole-vector reference model.
module tb_softmax_argmax_decoder;

  localparam int unsigned NC    = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned IW    = 4;
  localparam int unsigned BUS_W = NC * DW;
  localparam logic [DW-1:0] THRESH = 16'h4000;

  logic             clk = 1'b0;
  logic             rst;
  logic [BUS_W-1:0] softmax_in;
  logic             in_valid;
  logic             busy;
  logic [IW-1:0]    class_id;
  logic [DW-1:0]    class_prob;
  logic [IW-1:0]    second_id;
  logic [DW-1:0]    margin;
  logic             confident;
  logic             out_valid;
  logic             overrun;

  int tests = 0;
  int fails = 0;

  softmax_argmax_decoder #(
    .NUM_CLASSES (NC),
    .DATA_W      (DW),
    .CONF_THRESH (THRESH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .softmax_in (softmax_in),
    .in_valid   (in_valid),
    .busy       (busy),
    .class_id   (class_id),
    .class_prob (class_prob),
    .second_id  (second_id),
    .margin     (margin),
    .confident  (confident),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Top-1: largest value, lowest index on ties. Top-2: same rule over the remaining lanes.
  function automatic void model(input logic [BUS_W-1:0] vec,
                                output logic [IW-1:0] cid, output logic [DW-1:0] cp,
                                output logic [IW-1:0] sid, output logic [DW-1:0] mg,
                                output logic conf);
    int b;
    int s;
    logic [DW-1:0] v [NC];
    for (int i = 0; i < NC; i++) v[i] = vec[i*DW +: DW];
    b = 0;
    for (int i = 1; i < NC; i++) if (v[i] > v[b]) b = i;
    s = -1;
    for (int i = 0; i < NC; i++) if (i != b && (s < 0 || v[i] > v[s])) s = i;
    cid  = IW'(b);
    cp   = v[b];
    sid  = (s < 0) ? '0 : IW'(s);
    mg   = v[b] - ((s < 0) ? '0 : v[s]);
    conf = (v[b] >= THRESH);
  endfunction

  task automatic check_res(input string tag, input logic [BUS_W-1:0] vec);
    logic [IW-1:0] cid, sid;
    logic [DW-1:0] cp, mg;
    logic conf;
    model(vec, cid, cp, sid, mg, conf);
    chk({tag, ".class_id"},   32'(class_id),   32'(cid));
    chk({tag, ".class_prob"}, 32'(class_prob), 32'(cp));
    chk({tag, ".second_id"},  32'(second_id),  32'(sid));
    chk({tag, ".margin"},     32'(margin),     32'(mg));
    chk({tag, ".confident"},  32'(confident),  32'(conf));
  endtask

  // Called at a negedge; leaves at the negedge after the accepting edge E0.
  task automatic apply(input logic [BUS_W-1:0] vec);
    softmax_in = vec;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) n++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [BUS_W-1:0] vec);
    int lat;
    logic [IW-1:0] cid, sid;
    logic [DW-1:0] cp, mg;
    logic conf;
    apply(vec);
    wait_out(lat);
    chk({tag, ".latency"}, 32'(lat), 32'd11);
    check_res(tag, vec);
    @(posedge clk);
    @(negedge clk);
    model(vec, cid, cp, sid, mg, conf);
    chk({tag, ".pulse_width"}, 32'(out_valid), 32'd0);
    chk({tag, ".hold"}, 32'(class_prob), 32'(cp));
  endtask

  function automatic logic [BUS_W-1:0] rand_vec(input bit narrow);
    logic [BUS_W-1:0] vec;
    for (int i = 0; i < NC; i++) begin
      vec[i*DW +: DW] = narrow ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 16'h8000));
    end
    return vec;
  endfunction

  initial begin
    logic [BUS_W-1:0] va, vb, vc;
    int lat, n;

    rst        = 1'b1;
    in_valid   = 1'b0;
    softmax_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.busy",      32'(busy),       32'd0);
    chk("reset.out_valid", 32'(out_valid),  32'd0);
    chk("reset.overrun",   32'(overrun),    32'd0);
    chk("reset.class_id",  32'(class_id),   32'd0);
    chk("reset.prob",      32'(class_prob), 32'd0);

    // Directed: clear winner with runner-up.
    for (int i = 0; i < NC; i++) va[i*DW +: DW] = 16'h0100;
    va[7*DW +: DW] = 16'h6000;
    va[2*DW +: DW] = 16'h1000;
    run_vec("d1", va);
    chk("d1.class_id_const", 32'(class_id),  32'd7);
    chk("d1.second_const",   32'(second_id), 32'd2);
    chk("d1.margin_const",   32'(margin),    32'h5000);
    chk("d1.conf_const",     32'(confident), 32'd1);

    // Directed: tie between lanes 3 and 5.
    va = '0;
    va[3*DW +: DW] = 16'h2000;
    va[5*DW +: DW] = 16'h2000;
    run_vec("d2", va);
    chk("d2.class_id_const", 32'(class_id),  32'd3);
    chk("d2.second_const",   32'(second_id), 32'd5);
    chk("d2.margin_const",   32'(margin),    32'd0);

    // Directed: all zeros.
    va = '0;
    run_vec("d3", va);
    chk("d3.class_id_const", 32'(class_id),  32'd0);
    chk("d3.second_const",   32'(second_id), 32'd1);
    chk("d3.conf_const",     32'(confident), 32'd0);

    // Randomized vectors, half with narrow values to force ties.
    for (int t = 0; t < 24; t++) begin
      va = rand_vec(t[0]);
      run_vec($sformatf("rnd%0d", t), va);
    end

    // Overrun mid-scan while the bus keeps changing.
    va = rand_vec(1'b0);
    vb = rand_vec(1'b0);
    apply(va);
    for (int k = 0; k < 3; k++) begin
      softmax_in = rand_vec(1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    softmax_in = vb;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    softmax_in = rand_vec(1'b1);
    chk("ovr.pulse", 32'(overrun), 32'd1);
    chk("ovr.busy",  32'(busy),    32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("ovr.pulse_end", 32'(overrun), 32'd0);
    wait_out(lat);
    chk("ovr.latency", 32'(lat + 5), 32'd11);
    check_res("ovr", va);
    count_pulses(20, n);
    chk("ovr.single_out", 32'(n), 32'd0);

    // Reset in the middle of a scan.
    vc = rand_vec(1'b0);
    apply(vc);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.busy",      32'(busy),       32'd0);
    chk("rst.out_valid", 32'(out_valid),  32'd0);
    chk("rst.class_id",  32'(class_id),   32'd0);
    chk("rst.prob",      32'(class_prob), 32'd0);
    chk("rst.margin",    32'(margin),     32'd0);
    count_pulses(20, n);
    chk("rst.no_out", 32'(n), 32'd0);
    va = '0;
    va[9*DW +: DW] = 16'h7FFF;
    run_vec("rst_new", va);
    chk("rst_new.class_const", 32'(class_id),  32'd9);
    chk("rst_new.conf_const",  32'(confident), 32'd1);

    // in_valid during the out_valid cycle is dropped; one cycle later it is accepted.
    va = rand_vec(1'b0);
    vb = rand_vec(1'b0);
    apply(va);
    wait_out(lat);
    chk("bb.latency_a", 32'(lat), 32'd11);
    check_res("bb_a", va);
    softmax_in = vb;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bb.overrun",   32'(overrun),   32'd1);
    chk("bb.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bb.busy_accept", 32'(busy), 32'd1);
    check_res("bb_hold", va);
    wait_out(lat);
    chk("bb.latency_b", 32'(lat), 32'd11);
    check_res("bb_b", vb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
